// File: rtl/life_sequencer.sv
// Player-life sequencer: death freeze, respawn, invulnerability blink and game over.
// Optional score-driven bonus lives are built only when LIFE_BONUS_EN is defined.
module life_sequencer #(
  parameter int          INIT_LIVES    = 3,
  parameter int          MAX_LIVES     = 5,
  parameter int          DYING_FRAMES  = 60,
  parameter int          INVULN_FRAMES = 90,
  parameter int          BLINK_SHIFT   = 3,
  parameter logic [15:0] BONUS_STEP    = 16'd5000
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 playGame,
  input  logic                 hit,
  input  logic [15:0]          score,
  output logic                 player_died,
  output logic [2:0]           lives_count,
  output logic [MAX_LIVES-1:0] lives_mask,
  output logic                 freeze_player,
  output logic                 respawn,
  output logic                 invulnerable,
  output logic                 player_visible,
  output logic                 game_over,
  output logic [2:0]           dbg_state_o
);

  localparam int CNT_MAX = (DYING_FRAMES > INVULN_FRAMES) ? DYING_FRAMES : INVULN_FRAMES;
  localparam int CW_RAW  = $clog2(CNT_MAX + 1);
  localparam int CW      = (CW_RAW > BLINK_SHIFT) ? CW_RAW : BLINK_SHIFT + 1;

  localparam logic [CW-1:0] DYING_LAST  = CW'(DYING_FRAMES - 1);
  localparam logic [CW-1:0] INVULN_LAST = CW'(INVULN_FRAMES - 1);
  localparam logic [2:0]    INIT_L      = 3'(INIT_LIVES);
  localparam logic [2:0]    MAX_L       = 3'(MAX_LIVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIVE,
    S_DYING,
    S_RESPAWN,
    S_INVULN,
    S_GAME_OVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    lives_q, lives_d;
  logic          play_q;
  logic          died_q, died_d;
  logic          start_q, start_d;
  logic          play_rise, play_fall;
  logic          start_game;
  logic          dec_life;
  logic          inc_life;

  assign play_rise = playGame & ~play_q;
  assign play_fall = ~playGame & play_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    died_d     = 1'b0;
    start_d    = 1'b0;
    start_game = 1'b0;
    dec_life   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (play_rise) begin
          state_d    = S_ALIVE;
          start_d    = 1'b1;
          start_game = 1'b1;
        end
      end
      S_ALIVE: begin
        // Abandoning the game wins over a coincident hit: no death is charged.
        if (!playGame) begin
          state_d = S_IDLE;
        end else if (hit) begin
          state_d  = S_DYING;
          died_d   = 1'b1;
          dec_life = 1'b1;
        end
      end
      S_DYING: begin
        if (!playGame) begin
          state_d = S_IDLE;
        end else if (startOfFrame) begin
          if (cnt_q == DYING_LAST) begin
            state_d = (lives_q == 3'd0) ? S_GAME_OVER : S_RESPAWN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_RESPAWN: begin
        state_d = playGame ? S_INVULN : S_IDLE;
      end
      S_INVULN: begin
        if (!playGame) begin
          state_d = S_IDLE;
        end else if (startOfFrame) begin
          if (cnt_q == INVULN_LAST) begin
            state_d = S_ALIVE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_GAME_OVER: begin
        if (play_fall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Every state entry restarts the frame timer, so a coincident frame pulse is not counted.
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

`ifdef LIFE_BONUS_EN
  logic [15:0] thresh_q, thresh_d;
  logic        bonus_off_q, bonus_off_d;
  logic [16:0] thresh_sum;

  always_comb begin
    thresh_sum  = {1'b0, thresh_q} + {1'b0, BONUS_STEP};
    thresh_d    = thresh_q;
    bonus_off_d = bonus_off_q;
    inc_life    = 1'b0;
    if (start_game) begin
      thresh_d    = BONUS_STEP;
      bonus_off_d = 1'b0;
    end else if (state_q != S_IDLE && state_q != S_GAME_OVER &&
                 !bonus_off_q && score >= thresh_q) begin
      inc_life    = 1'b1;
      thresh_d    = thresh_sum[15:0];
      bonus_off_d = thresh_sum[16];
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      thresh_q    <= BONUS_STEP;
      bonus_off_q <= 1'b0;
    end else begin
      thresh_q    <= thresh_d;
      bonus_off_q <= bonus_off_d;
    end
  end
`else
  logic unused_score;
  assign unused_score = ^score;
  assign inc_life     = 1'b0;
`endif

  always_comb begin
    lives_d = lives_q;
    if (start_game) begin
      lives_d = INIT_L;
    end else if (dec_life && !inc_life) begin
      lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : lives_q;
    end else if (inc_life && !dec_life) begin
      lives_d = (lives_q < MAX_L) ? lives_q + 3'd1 : lives_q;
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lives_q <= INIT_L;
      play_q  <= 1'b0;
      died_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lives_q <= lives_d;
      play_q  <= playGame;
      died_q  <= died_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    freeze_player  = 1'b1;
    player_visible = 1'b0;
    invulnerable   = 1'b0;
    game_over      = 1'b0;
    case (state_q)
      S_ALIVE: begin
        freeze_player  = 1'b0;
        player_visible = 1'b1;
      end
      S_DYING, S_RESPAWN: player_visible = 1'b1;
      S_INVULN: begin
        freeze_player  = 1'b0;
        invulnerable   = 1'b1;
        player_visible = ~cnt_q[BLINK_SHIFT];
      end
      S_GAME_OVER: game_over = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < MAX_LIVES; i++) begin
      lives_mask[i] = (int'(lives_q) > i);
    end
  end

  assign player_died = died_q;
  assign respawn     = start_q | (state_q == S_RESPAWN);
  assign lives_count = lives_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer: death sequence timing, blink, game over, reset and bonus lives.
module tb_life_sequencer;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        playGame;
  logic        hit;
  logic [15:0] score;
  logic        player_died;
  logic [2:0]  lives_count;
  logic [4:0]  lives_mask;
  logic        freeze_player;
  logic        respawn;
  logic        invulnerable;
  logic        player_visible;
  logic        game_over;
  logic [2:0]  unused_dbg_state;

  int checks   = 0;
  int failures = 0;
  int died_cnt = 0;
  int resp_cnt = 0;

  life_sequencer dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .playGame      (playGame),
    .hit           (hit),
    .score         (score),
    .player_died   (player_died),
    .lives_count   (lives_count),
    .lives_mask    (lives_mask),
    .freeze_player (freeze_player),
    .respawn       (respawn),
    .invulnerable  (invulnerable),
    .player_visible(player_visible),
    .game_over     (game_over),
    .dbg_state_o   (unused_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    if (respawn) resp_cnt++;
    if (player_died) died_cnt++;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      step();
      startOfFrame = 1'b0;
      step();
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_lives"}, 16'(lives_count), 16'd3);
    check({tag, "_mask"}, 16'(lives_mask), 16'h0007);
    check({tag, "_game_over"}, 16'(game_over), 16'd0);
    check({tag, "_died"}, 16'(player_died), 16'd0);
    check({tag, "_respawn"}, 16'(respawn), 16'd0);
    check({tag, "_freeze"}, 16'(freeze_player), 16'd1);
    check({tag, "_invuln"}, 16'(invulnerable), 16'd0);
    check({tag, "_visible"}, 16'(player_visible), 16'd0);
  endtask

  initial begin
    resetN = 1'b1; startOfFrame = 1'b0; playGame = 1'b0; hit = 1'b0; score = 16'd0;
    step(); step(); step();
    check_idle_reset("reset");
    resetN = 1'b0;
    step();
    check("idle_freeze", 16'(freeze_player), 16'd1);
    died_cnt = 0; resp_cnt = 0;

    // Game start
    playGame = 1'b1;
    step();
    check("start_respawn", 16'(respawn), 16'd1);
    check("start_lives", 16'(lives_count), 16'd3);
    check("alive_freeze", 16'(freeze_player), 16'd0);
    check("alive_visible", 16'(player_visible), 16'd1);
    step();
    check("start_respawn_end", 16'(respawn), 16'd0);

    // First death with hit held through the whole dying period
    hit = 1'b1;
    step();
    check("hit1_died", 16'(player_died), 16'd1);
    check("hit1_lives", 16'(lives_count), 16'd2);
    check("hit1_mask", 16'(lives_mask), 16'h0003);
    check("dying_freeze", 16'(freeze_player), 16'd1);
    step(); step(); step(); step(); step();
    check("hit1_pulse_end", 16'(player_died), 16'd0);
    check("held_hit_one_death", 16'(died_cnt), 16'd1);
    frames(59);
    check("dying59_freeze", 16'(freeze_player), 16'd1);
    check("dying59_no_respawn", 16'(resp_cnt), 16'd1);
    check("dying59_lives", 16'(lives_count), 16'd2);
    frames(1);
    check("dying60_respawn", 16'(resp_cnt), 16'd2);
    check("invuln_on", 16'(invulnerable), 16'd1);
    check("invuln_freeze", 16'(freeze_player), 16'd0);
    check("invuln_visible0", 16'(player_visible), 16'd1);
    hit = 1'b0;
    frames(7);
    check("invuln_visible7", 16'(player_visible), 16'd1);
    frames(1);
    check("invuln_visible8", 16'(player_visible), 16'd0);
    frames(8);
    check("invuln_visible16", 16'(player_visible), 16'd1);
    hit = 1'b1;
    step(); step(); step();
    hit = 1'b0;
    check("invuln_hit_died", 16'(died_cnt), 16'd1);
    check("invuln_hit_lives", 16'(lives_count), 16'd2);
    frames(73);
    check("invuln89_on", 16'(invulnerable), 16'd1);
    frames(1);
    check("invuln90_off", 16'(invulnerable), 16'd0);
    check("alive_again_freeze", 16'(freeze_player), 16'd0);

    // Second death: frame pulse on the hit cycle must not count
    hit = 1'b1; startOfFrame = 1'b1;
    step();
    hit = 1'b0; startOfFrame = 1'b0;
    check("hit2_died", 16'(player_died), 16'd1);
    check("hit2_lives", 16'(lives_count), 16'd1);
    frames(59);
    check("hit2_dying59", 16'(freeze_player), 16'd1);
    check("hit2_no_respawn", 16'(resp_cnt), 16'd2);
    frames(1);
    check("hit2_respawn", 16'(resp_cnt), 16'd3);
    check("hit2_invuln", 16'(invulnerable), 16'd1);
    frames(90);
    check("hit2_invuln_end", 16'(invulnerable), 16'd0);

    // Third death leads to game over
    hit = 1'b1;
    step();
    hit = 1'b0;
    check("hit3_lives", 16'(lives_count), 16'd0);
    check("hit3_mask", 16'(lives_mask), 16'h0000);
    frames(60);
    check("gameover_on", 16'(game_over), 16'd1);
    check("gameover_freeze", 16'(freeze_player), 16'd1);
    check("gameover_visible", 16'(player_visible), 16'd0);
    check("gameover_no_respawn", 16'(resp_cnt), 16'd3);
    check("gameover_deaths", 16'(died_cnt), 16'd3);
    frames(5);
    check("gameover_hold", 16'(game_over), 16'd1);
    playGame = 1'b0;
    step();
    check("gameover_exit", 16'(game_over), 16'd0);
    check("gameover_exit_freeze", 16'(freeze_player), 16'd1);

    // Reset in the middle of a dying period
    playGame = 1'b1;
    step();
    check("restart_lives", 16'(lives_count), 16'd3);
    hit = 1'b1;
    step();
    hit = 1'b0;
    frames(10);
    resetN = 1'b1; playGame = 1'b0;
    step();
    check_idle_reset("mid_dying_reset");
    resetN = 1'b0;
    step();

    // Quitting mid-sequence keeps lives until the next start
    playGame = 1'b1;
    step();
    hit = 1'b1;
    step();
    hit = 1'b0;
    check("quit_lives_before", 16'(lives_count), 16'd2);
    frames(3);
    died_cnt = 0;
    playGame = 1'b0; hit = 1'b1;
    step();
    hit = 1'b0;
    check("quit_freeze", 16'(freeze_player), 16'd1);
    check("quit_visible", 16'(player_visible), 16'd0);
    check("quit_lives_kept", 16'(lives_count), 16'd2);
    check("quit_no_death", 16'(died_cnt), 16'd0);
    playGame = 1'b1;
    step();
    check("restart2_lives", 16'(lives_count), 16'd3);

`ifdef LIFE_BONUS_EN
    hit = 1'b1;
    step();
    hit = 1'b0;
    frames(60);
    frames(90);
    check("bonus_pre_lives", 16'(lives_count), 16'd2);
    score = 16'd5000; hit = 1'b1;
    step();
    hit = 1'b0;
    check("bonus_hit_died", 16'(player_died), 16'd1);
    check("bonus_hit_lives", 16'(lives_count), 16'd2);
    score = 16'd10000;
    step();
    check("bonus_10000", 16'(lives_count), 16'd3);
    score = 16'hFFFF;
    step();
    check("bonus_15000", 16'(lives_count), 16'd4);
    for (int i = 0; i < 20; i++) step();
    check("bonus_saturate", 16'(lives_count), 16'd5);
    check("bonus_mask", 16'(lives_mask), 16'h001F);
`else
    for (int s = 0; s <= 65535; s += 4369) begin
      score = 16'(s);
      step();
      check("score_sweep_lives", 16'(lives_count), 16'd3);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
- Controls the player-life resource for the Digger game.
- Accepts collision hits and sequences each death: freeze, death-animation wait, respawn, invulnerability window.
- Owns the life count and drives the lives display bitmap with a one-cycle death pulse and a life mask.
- Declares game over when the last life is lost.

Parameters:
- INIT_LIVES, 3, lives loaded at reset and at game start (1..MAX_LIVES).
- MAX_LIVES, 5, saturation ceiling for the life count (≤7).
- DYING_FRAMES, 60, frames the player stays frozen after a hit.
- INVULN_FRAMES, 90, frames of hit immunity after respawn.
- BLINK_SHIFT, 3, frame-counter bit that toggles the visibility blink.
- BONUS_STEP, 16'd5000, score increment per bonus life (used only with LIFE_BONUS_EN).

Ports:
- clk  in  1  system clock.
- resetN  in  1  synchronous reset, active-high despite the name (name kept for top-level wiring). Sampled on the rising edge of clk.
- startOfFrame  in  1  one-cycle pulse per video frame; all timers count these pulses.
- playGame  in  1  level: game running. Rising edge starts a new game.
- hit  in  1  player/monster collision this cycle; may be held for many cycles.
- score  in  16  current score, unsigned.
- player_died  out  1  one-cycle pulse per life lost, to the lives bitmap.
- lives_count  out  3  current lives.
- lives_mask  out  MAX_LIVES  thermometer mask; bit i = 1 iff i < lives_count.
- freeze_player  out  1  player movement disabled.
- respawn  out  1  one-cycle pulse: reload player start position.
- invulnerable  out  1  hits currently ignored.
- player_visible  out  1  player sprite enable (blinks during invulnerability).
- game_over  out  1  level, stays high until new game or reset.

Behaviour:
Reset:
- State = IDLE, lives_count = INIT_LIVES, frame counter = 0.
- All pulse outputs = 0, game_over = 0, freeze_player = 1, invulnerable = 0, player_visible = 0.
- Reset overrides everything, including a mid-sequence state.

States:
- IDLE
  - freeze_player = 1.
  - playGame rising edge (registered previous value) → ALIVE; lives_count reloads INIT_LIVES and respawn pulses in the same cycle.
- ALIVE
  - player_visible = 1, freeze_player = 0.
  - hit = 1 → DYING on the next edge. player_died pulses exactly one cycle (the transition cycle registered). lives_count decrements by 1 in that same cycle. Frame counter clears.
- DYING
  - freeze_player = 1, player_visible = 1, hit ignored.
  - Frame counter increments on startOfFrame.
  - On reaching DYING_FRAMES: lives_count == 0 → GAME_OVER; else → RESPAWN.
- RESPAWN
  - One-cycle state: respawn = 1, counter clears, → INVULN.
- INVULN
  - invulnerable = 1, freeze_player = 0, hit ignored.
  - player_visible = NOT counter[BLINK_SHIFT].
  - On counter reaching INVULN_FRAMES → ALIVE.
- GAME_OVER
  - game_over = 1, freeze_player = 1, player_visible = 0.
  - playGame falling edge → IDLE.

Lives arithmetic:
- Unsigned 3-bit. Decrement only on an ALIVE→DYING transition, never below 0.
- Bonus increment saturates at MAX_LIVES.
- Decrement and increment in the same cycle: net change 0. player_died still pulses.
- lives_mask is combinational from lives_count.

Other rules:
- A held hit produces exactly one death. A new death needs re-entry to ALIVE with hit still high; a hit held through INVULN kills on the first ALIVE cycle.
- startOfFrame coincident with a state entry does not count toward the new state's timer.
- playGame dropping in ALIVE, DYING, RESPAWN or INVULN → IDLE with no death pulse; lives are retained until the next game start.

Optional Feature:
LIFE_BONUS_EN:
- Defined:
  - An internal 16-bit threshold register resets to BONUS_STEP and reloads BONUS_STEP at game start.
  - When score ≥ threshold in any state except IDLE and GAME_OVER, lives_count increments (saturating) and threshold += BONUS_STEP.
  - At most one bonus per cycle.
  - Threshold overflow past 16'hFFFF disables further bonuses.
- Undefined: score is unused and lives only decrease.

Test Plan:
- Reset mid-DYING → next cycle: IDLE, lives_count = 3, lives_mask = 5'b00111, game_over = 0, all pulses 0.
- Game start, hit held 200 cycles:
  - player_died high exactly 1 cycle, lives_count 3→2.
  - After 60 startOfFrame pulses, respawn pulses once.
  - invulnerable high for 90 frames; player_visible toggles every 8 frames.
- Three hits, each after invulnerability ends: lives 3→2→1→0. After the third DYING period, game_over = 1 and no further respawn. playGame 1→0 → IDLE.
- hit asserted during DYING and INVULN → no player_died pulse, lives_count unchanged.
- LIFE_BONUS_EN, lives = 2:
  - score steps to 5000 in the same cycle as hit → player_died pulses, lives_count stays 2.
  - score reaches 10000 → lives 3.
  - Repeated bonuses saturate at 5.
- Without LIFE_BONUS_EN: score swept 0→65535 → lives_count unchanged.
